// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, ALU encodings and the ID/EX control word
package id_ex_stage_pkg;
   localparam int XLEN = 32;
   localparam int REGW = 5;
   typedef enum logic [3:0] {
      ALU_AND  = 4'b0000,
      ALU_OR   = 4'b0001,
      ALU_ADD  = 4'b0010,
      ALU_SUB  = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_op_e;
   typedef struct packed {
      logic       valid;
      logic [3:0] alu_op;
      logic       src_a_pc;
      logic       src_b_imm;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
   } ctrl_t;
   localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: per-operand select between EX/MEM result, MEM/WB result and register-file data
module fwd_mux import id_ex_stage_pkg::*; (
   input  logic [REGW-1:0] rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic [REGW-1:0] exm_rd,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [REGW-1:0] wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_result,
   output logic [XLEN-1:0] fwd
);
   // youngest producer wins; x0 is hardwired zero so it is never forwarded
   always_comb
      fwd = (exm_reg_write && exm_rd != '0 && exm_rd == rs) ? exm_result :
            (wb_reg_write && wb_rd != '0 && wb_rd == rs)    ? wb_result  : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_stage import id_ex_stage_pkg::*; (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [3:0]      id_alu_op,
   input  logic            id_src_a_pc,
   input  logic            id_src_b_imm,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            stall_in,
   input  logic            flush,
   input  logic [REGW-1:0] exm_rd,
   input  logic            exm_reg_write,
   input  logic [XLEN-1:0] exm_result,
   input  logic [REGW-1:0] wb_rd,
   input  logic            wb_reg_write,
   input  logic [XLEN-1:0] wb_result,
   output logic            hazard_stall,
   output logic            ex_valid,
   output logic [3:0]      ex_alu_op,
   output logic [XLEN-1:0] ex_ina,
   output logic [XLEN-1:0] ex_inb,
   output logic [XLEN-1:0] ex_store_data,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic [XLEN-1:0] ex_pc
);
   ctrl_t           ctrl;
   ctrl_t           id_ctrl;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic [REGW-1:0] rs1;
   logic [REGW-1:0] rs2;
   logic [REGW-1:0] rd;
   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;

   assign id_ctrl = '{valid: id_valid, alu_op: id_alu_op, src_a_pc: id_src_a_pc,
                      src_b_imm: id_src_b_imm, reg_write: id_reg_write,
                      mem_read: id_mem_read, mem_write: id_mem_write};

   // a load in EX cannot forward its data yet, so a dependent decode instruction must wait
   assign hazard_stall = ctrl.valid & ctrl.mem_read & (rd != '0) & id_valid &
                         ((id_rs1 == rd) | (id_rs2 == rd));

   // flush beats hold; a bubble on hazard leaves data fields as they were
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ctrl     <= BUBBLE;
         pc       <= '0;
         rs1_data <= '0;
         rs2_data <= '0;
         imm      <= '0;
         rs1      <= '0;
         rs2      <= '0;
         rd       <= '0;
      end else if (flush || (!stall_in && hazard_stall)) begin
         ctrl <= BUBBLE;
      end else if (!stall_in) begin
         ctrl     <= id_ctrl;
         pc       <= id_pc;
         rs1_data <= id_rs1_data;
         rs2_data <= id_rs2_data;
         imm      <= id_imm;
         rs1      <= id_rs1;
         rs2      <= id_rs2;
         rd       <= id_rd;
      end

   fwd_mux u_fwd1 (.rs(rs1), .rf_data(rs1_data), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
                   .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
                   .wb_result(wb_result), .fwd(fwd1));
   fwd_mux u_fwd2 (.rs(rs2), .rf_data(rs2_data), .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
                   .exm_result(exm_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
                   .wb_result(wb_result), .fwd(fwd2));

   assign ex_valid      = ctrl.valid;
   assign ex_alu_op     = ctrl.valid ? ctrl.alu_op : ALU_AND;
   assign ex_reg_write  = ctrl.valid & ctrl.reg_write;
   assign ex_mem_read   = ctrl.valid & ctrl.mem_read;
   assign ex_mem_write  = ctrl.valid & ctrl.mem_write;
   assign ex_ina        = ctrl.src_a_pc ? pc : fwd1;
   assign ex_inb        = ctrl.src_b_imm ? imm : fwd2;
   assign ex_store_data = fwd2;
   assign ex_rd         = rd;
   assign ex_pc         = pc;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with operand forwarding and load-use hazard detection. It sits directly upstream of the ALU.
- Captures decoded instruction fields from the decode stage and resolves forwarded operands from EX/MEM and MEM/WB.
- Presents ALU operation code and both ALU operands, plus store data and control forwarded to the EX/MEM register.
- Inserts bubbles on load-use hazards and on flush.

Parameters:
XLEN, 32, datapath width (PC, register data, immediate, ALU operands)
REGW, 5, register index width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  register file read port 1
id_rs2_data  in  XLEN  register file read port 2
id_imm  in  XLEN  sign-extended immediate
id_rs1  in  REGW  source register 1 index
id_rs2  in  REGW  source register 2 index
id_rd  in  REGW  destination index
id_alu_op  in  4  ALU operation code (0000 AND … 1001 SRA)
id_src_a_pc  in  1  operand A = PC instead of rs1
id_src_b_imm  in  1  operand B = imm instead of rs2
id_reg_write  in  1  writes rd
id_mem_read  in  1  load
id_mem_write  in  1  store
stall_in  in  1  downstream hold; stage keeps contents
flush  in  1  squash (taken branch/jump)
exm_rd  in  REGW  EX/MEM destination
exm_reg_write  in  1  EX/MEM writes rd
exm_result  in  XLEN  EX/MEM ALU result
wb_rd  in  REGW  MEM/WB destination
wb_reg_write  in  1  MEM/WB writes rd
wb_result  in  XLEN  MEM/WB writeback value
hazard_stall  out  1  upstream must hold PC and IF/ID
ex_valid  out  1  stage holds a valid instruction
ex_alu_op  out  4  to ALU
ex_ina  out  XLEN  ALU operand A
ex_inb  out  XLEN  ALU operand B
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  REGW  destination index
ex_reg_write  out  1  gated by ex_valid
ex_mem_read  out  1  gated by ex_valid
ex_mem_write  out  1  gated by ex_valid
ex_pc  out  XLEN  registered PC

Behaviour:
- Reset (async, rst_n=0): all registered fields 0; ex_valid=0; all control outputs 0; ex_alu_op=0000; hazard_stall=0.
- Load-use detection (combinational):
  - hazard_stall = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (id_rs1==ex_rd | id_rs2==ex_rd).
  - Evaluated against current register contents.
- Per-edge update, priority order:
  - flush=1 → bubble: valid=0, controls 0. Overrides stall_in.
  - stall_in=1 → hold all fields unchanged.
  - hazard_stall=1 → bubble loaded; the decode instruction is retained upstream.
  - otherwise → capture all id_* fields; valid=id_valid.
- Latency: 1 cycle decode→EX.
- When valid=0: ex_reg_write, ex_mem_read, ex_mem_write are forced 0 and ex_alu_op=0000. Data outputs are don't-care but deterministic.
- Forwarding (combinational from registered rs1/rs2), applied independently per operand:
  - EX/MEM match (exm_reg_write & exm_rd≠0 & exm_rd==rsX) → exm_result.
  - else MEM/WB match (same rule with wb_*) → wb_result.
  - else registered register-file data.
  - x0 is never forwarded. EX/MEM wins when both match.
- Operand selection:
  - ex_ina = src_a_pc ? pc : fwd_rs1.
  - ex_inb = src_b_imm ? imm : fwd_rs2.
  - ex_store_data = fwd_rs2 always.
- Stall hold: forwarding continues to track current exm/wb inputs each cycle.
- Reset asserted mid-stall or mid-hazard: immediate clear; hazard_stall drops with ex_valid.

Decomposition:
- Shared package:
  - ALU op encodings (ALU_AND=0000 … ALU_SRA=1001).
  - XLEN, REGW.
  - Bubble/control-word constant.
- One natural sub-module: fwd_mux. It performs the per-operand 3-way forwarding select and is instantiated twice (rs1, rs2).

Test Plan:
- Reset then capture: id ADD (alu_op=0010, rs1_data=5, rs2_data=7, rd=3, reg_write=1) → next cycle ex_alu_op=0010, ex_ina=5, ex_inb=7, ex_reg_write=1.
- Double forwarding: ex rs1=4, exm_rd=4 exm_result=0xAAAA, wb_rd=4 wb_result=0xBBBB, both write=1 → ex_ina=0xAAAA. Drop exm_reg_write → 0xBBBB.
- x0 guard: rs2=0, exm_rd=0, exm_reg_write=1, exm_result=0xFFFF, rs2_data=0 → ex_inb=0.
- Load-use: ex holds load rd=6; id instruction rs2=6 → hazard_stall=1. Next cycle ex_valid=0, controls 0, hazard_stall=0. Following cycle the dependent instruction is captured.
- Flush beats stall: stall_in=1 and flush=1 with valid store in ex → next cycle ex_valid=0, ex_mem_write=0.
- Async reset mid-operation: rst_n low between edges → all outputs 0 immediately, without waiting for clk.
